// File: rtl/input_controller_pkg.sv
// input_controller_pkg: command codes, button indices and helpers shared by the input front end.
package input_controller_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_DEAL  = 2'd1,
        CMD_HIT   = 2'd2,
        CMD_STAND = 2'd3
    } command;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ctrlState;

    localparam int BTN_DEAL  = 0;
    localparam int BTN_HIT   = 1;
    localparam int BTN_STAND = 2;

    // Priority DEAL > STAND > HIT among the legal presses of one cycle.
    function automatic command pickCommand(input logic [2:0] legal);
        return legal[BTN_DEAL]  ? CMD_DEAL  :
               legal[BTN_STAND] ? CMD_STAND :
               legal[BTN_HIT]   ? CMD_HIT   : CMD_NONE;
    endfunction

    // More than one legal press in the same cycle means the losers are dropped.
    function automatic logic severalSet(input logic [2:0] legal);
        return (legal & (legal - 3'd1)) != 3'd0;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronise, debounce and edge-detect one active-low pushbutton.
// Ports: clk, reset_n (async active-low), keyN (raw active-low key),
//        level (debounced active-high level), rise (one-cycle pulse on level 0->1).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic keyN,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] syncN;
    logic synced;
    logic levelPrev;
    logic [CW-1:0] count;

    assign synced = ~syncN[1];
    assign rise = level & ~levelPrev;

    // Synchroniser resets to the released (high) key level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncN <= 2'b11;
            count <= '0;
            level <= 1'b0;
            levelPrev <= 1'b0;
        end else begin
            syncN <= {syncN[0], keyN};
            levelPrev <= level;
            if (synced == level)
                count <= '0;
            else if (count == LAST) begin
                level <= synced;
                count <= '0;
            end else
                count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/input_controller.sv
// input_controller: debounced pushbuttons to game commands over a valid/ready handshake.
// Ports: clk, reset_n (async active-low), key_n[2:0] raw active-low keys (DEAL,HIT,STAND),
//        accept_mask[2:0] legal commands, cmd_ready from the game FSM,
//        cmd_valid/cmd pending command, btn_level[2:0] debounced levels,
//        overrun one-cycle pulse when a legal press is dropped.
module input_controller
    import input_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] key_n,
    input  logic [2:0] accept_mask,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output command     cmd,
    output logic [2:0] btn_level,
    output logic       overrun
);
    ctrlState state, stateNext;
    command cmdNext;
    logic overrunNext;
    logic [2:0] presses;
    logic [2:0] legal;

    for (genvar g = 0; g < 3; g++) begin : gDeb
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDeb (
            .clk(clk),
            .reset_n(reset_n),
            .keyN(key_n[g]),
            .level(btn_level[g]),
            .rise(presses[g])
        );
    end

    assign legal = presses & accept_mask;
    assign cmd_valid = state == PENDING;

    // Any legal press seen while a command is outstanding is an overrun,
    // including the cycle in which the handshake completes.
    always_comb begin
        stateNext = state;
        cmdNext = cmd;
        overrunNext = 1'b0;
        if (state == IDLE) begin
            if (legal != 3'd0) begin
                stateNext = PENDING;
                cmdNext = pickCommand(legal);
                overrunNext = severalSet(legal);
            end
        end else begin
            overrunNext = legal != 3'd0;
            if (cmd_ready) begin
                stateNext = IDLE;
                cmdNext = CMD_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cmd <= CMD_NONE;
            overrun <= 1'b0;
        end else begin
            state <= stateNext;
            cmd <= cmdNext;
            overrun <= overrunNext;
        end
    end

endmodule

// File: tb/tb_input_controller.sv
// tb_input_controller: directed checks of debounce timing, priority, masking, backpressure and reset.
module tb_input_controller;
    import input_controller_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic [2:0] key_n;
    logic [2:0] accept_mask;
    logic cmd_ready;
    logic cmd_valid;
    command cmd;
    logic [2:0] btn_level;
    logic overrun;

    int total = 0;
    int bad = 0;
    int handshakes = 0;
    int overruns = 0;
    logic [1:0] lastCmd = 2'd0;

    input_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key_n(key_n),
        .accept_mask(accept_mask),
        .cmd_ready(cmd_ready),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .btn_level(btn_level),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Transfers and overrun pulses as the DUT's flops see them.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) begin
            handshakes++;
            lastCmd = cmd;
        end
        if (overrun)
            overruns++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int hs0, ov0;
    logic sawHigh;

    initial begin
        reset_n = 1'b0;
        key_n = 3'b000;
        accept_mask = 3'b111;
        cmd_ready = 1'b0;
        tick(4);
        check("rst_valid", cmd_valid, 0);
        check("rst_cmd", cmd, CMD_NONE);
        check("rst_level", btn_level, 0);
        check("rst_overrun", overrun, 0);
        key_n = 3'b111;
        tick(1);
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        tick(10);

        // Clean HIT press
        hs0 = handshakes; ov0 = overruns;
        key_n[1] = 1'b0;
        tick(5);
        check("hit_level_early", btn_level[1], 0);
        tick(1);
        check("hit_level", btn_level[1], 1);
        check("hit_valid_early", cmd_valid, 0);
        tick(1);
        check("hit_valid", cmd_valid, 1);
        check("hit_cmd", cmd, CMD_HIT);
        tick(1);
        check("hit_valid_drop", cmd_valid, 0);
        check("hit_cmd_none", cmd, CMD_NONE);
        tick(12);
        check("hit_count", handshakes - hs0, 1);
        check("hit_last", lastCmd, CMD_HIT);
        check("hit_ovr", overruns - ov0, 0);
        key_n = 3'b111;
        tick(10);
        check("hit_release", btn_level, 0);

        // Bouncing STAND
        hs0 = handshakes;
        sawHigh = 1'b0;
        for (int k = 0; k < 6; k++) begin
            key_n[2] = k[0];
            for (int i = 0; i < 2; i++) begin
                tick(1);
                sawHigh |= btn_level[2];
            end
        end
        check("bounce_quiet", sawHigh, 0);
        key_n[2] = 1'b0;
        tick(5);
        check("bounce_level_early", btn_level[2], 0);
        tick(1);
        check("bounce_level", btn_level[2], 1);
        tick(14);
        check("bounce_count", handshakes - hs0, 1);
        check("bounce_last", lastCmd, CMD_STAND);
        key_n = 3'b111;
        tick(10);

        // Backpressure: STAND pending, HIT dropped
        cmd_ready = 1'b0;
        hs0 = handshakes; ov0 = overruns;
        key_n[2] = 1'b0;
        tick(7);
        check("bp_valid", cmd_valid, 1);
        check("bp_cmd", cmd, CMD_STAND);
        key_n[1] = 1'b0;
        tick(10);
        check("bp_cmd_hold", cmd, CMD_STAND);
        check("bp_valid_hold", cmd_valid, 1);
        check("bp_ovr", overruns - ov0, 1);
        cmd_ready = 1'b1;
        tick(1);
        check("bp_valid_drop", cmd_valid, 0);
        check("bp_cmd_none", cmd, CMD_NONE);
        check("bp_count", handshakes - hs0, 1);
        check("bp_last", lastCmd, CMD_STAND);
        key_n = 3'b111;
        tick(10);
        check("bp_count_after", handshakes - hs0, 1);

        // Simultaneous DEAL+HIT, both legal
        hs0 = handshakes; ov0 = overruns;
        key_n = 3'b100;
        tick(20);
        check("sim_count", handshakes - hs0, 1);
        check("sim_last", lastCmd, CMD_DEAL);
        check("sim_ovr", overruns - ov0, 1);
        key_n = 3'b111;
        tick(10);

        // Simultaneous DEAL+HIT, only DEAL legal
        accept_mask = 3'b001;
        hs0 = handshakes; ov0 = overruns;
        key_n = 3'b100;
        tick(20);
        check("simm_count", handshakes - hs0, 1);
        check("simm_last", lastCmd, CMD_DEAL);
        check("simm_ovr", overruns - ov0, 0);
        key_n = 3'b111;
        tick(10);

        // Masked HIT
        hs0 = handshakes; ov0 = overruns;
        key_n[1] = 1'b0;
        tick(6);
        check("mask_level", btn_level[1], 1);
        tick(14);
        check("mask_count", handshakes - hs0, 0);
        check("mask_ovr", overruns - ov0, 0);
        check("mask_valid", cmd_valid, 0);
        key_n = 3'b111;
        tick(10);

        // Asynchronous reset while PENDING, DEAL held through reset
        accept_mask = 3'b111;
        cmd_ready = 1'b0;
        key_n[0] = 1'b0;
        tick(7);
        check("arst_valid_before", cmd_valid, 1);
        reset_n = 1'b0;
        #1;
        check("arst_valid", cmd_valid, 0);
        check("arst_cmd", cmd, CMD_NONE);
        check("arst_level", btn_level, 0);
        tick(2);
        hs0 = handshakes;
        cmd_ready = 1'b1;
        reset_n = 1'b1;
        tick(20);
        check("held_count", handshakes - hs0, 1);
        check("held_last", lastCmd, CMD_DEAL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
